// File: rtl/gpu_pkg.sv
// Shared core definitions: core FSM state encodings, NZP bit positions and
// the immediate-to-PC width adapter.
package gpu_pkg;

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_FETCH   = 3'b001;
  localparam logic [2:0] ST_DECODE  = 3'b010;
  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_WAIT    = 3'b100;
  localparam logic [2:0] ST_EXECUTE = 3'b101;
  localparam logic [2:0] ST_UPDATE  = 3'b110;
  localparam logic [2:0] ST_DONE    = 3'b111;

  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;

  // Zero-extend or truncate an immediate to pc_bits; caller narrows the result.
  function automatic logic [31:0] imm_to_pc(input logic [31:0] imm, input int unsigned pc_bits);
    logic [31:0] mask;
    mask = (pc_bits >= 32) ? '1 : ((32'd1 << pc_bits) - 32'd1);
    return imm & mask;
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decoder/scheduler-facing bundle of the PC and branch unit.
interface pc_branch_unit_if #(
  parameter int unsigned THREADS               = 4,
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned DATA_MEM_DATA_BITS    = 8
);
  logic [THREADS-1:0]                         thread_enable;
  logic [2:0]                                 core_state;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]           current_pc;
  logic                                       decoded_pc_mux;
  logic [2:0]                                 decoded_nzp;
  logic [DATA_MEM_DATA_BITS-1:0]              decoded_immediate;
  logic                                       decoded_nzp_write_enable;
  logic                                       decoded_always_execute;
  logic [THREADS-1:0]                         predicate_mask;
  logic [THREADS*DATA_MEM_DATA_BITS-1:0]      alu_out;
  logic [THREADS*PROGRAM_MEM_ADDR_BITS-1:0]   next_pc;
  logic [THREADS*3-1:0]                       nzp;
  logic                                       next_pc_valid;
  logic                                       diverged;

  modport master (
    output thread_enable, core_state, current_pc, decoded_pc_mux, decoded_nzp,
           decoded_immediate, decoded_nzp_write_enable, decoded_always_execute,
           predicate_mask, alu_out,
    input  next_pc, nzp, next_pc_valid, diverged
  );

  modport slave (
    input  thread_enable, core_state, current_pc, decoded_pc_mux, decoded_nzp,
           decoded_immediate, decoded_nzp_write_enable, decoded_always_execute,
           predicate_mask, alu_out,
    output next_pc, nzp, next_pc_valid, diverged
  );
endinterface

// File: rtl/pc_lane.sv
// One thread lane: holds the lane's next PC and NZP register and resolves
// whether the current branch is taken for this lane.
module pc_lane
  import gpu_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        core_state,
  input  logic [PC_W-1:0]   current_pc,
  input  logic              pc_mux,
  input  logic [2:0]        decoded_nzp,
  input  logic [DATA_W-1:0] immediate,
  input  logic              nzp_write_enable,
  input  logic              always_execute,
  input  logic              predicate,
  input  logic [2:0]        cmp_result,
  output logic [PC_W-1:0]   next_pc,
  output logic [2:0]        nzp,
  output logic [PC_W-1:0]   next_pc_c
);

  logic            exec_c;
  logic            taken_c;
  logic [PC_W-1:0] target_c;
  logic [PC_W-1:0] pc_inc_c;

  // Predicated-off lanes still step to pc+1 so they stay in lockstep.
  always_comb begin
    exec_c    = always_execute | predicate;
    taken_c   = pc_mux & exec_c & (|(nzp & decoded_nzp));
    target_c  = PC_W'(imm_to_pc(32'(immediate), PC_W));
    pc_inc_c  = current_pc + PC_W'(1);
    next_pc_c = taken_c ? target_c : pc_inc_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_pc <= '0;
      nzp     <= '0;
    end else if (enable) begin
      if (core_state == ST_EXECUTE) next_pc <= next_pc_c;
      if (core_state == ST_UPDATE && nzp_write_enable) nzp <= cmp_result;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Per-thread PC and branch unit: one pc_lane per thread, divergence
// detection across enabled lanes, and the next_pc_valid pulse.
module pc_branch_unit
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS               = 4,
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned DATA_MEM_DATA_BITS    = 8
) (
  input  logic              clk,
  input  logic              reset,
  pc_branch_unit_if.slave   bus
);

  localparam int unsigned PC_W   = PROGRAM_MEM_ADDR_BITS;
  localparam int unsigned DATA_W = DATA_MEM_DATA_BITS;

  logic [PC_W-1:0]         lane_pc   [THREADS];
  logic [PC_W-1:0]         lane_pc_c [THREADS];
  logic [2:0]              lane_nzp  [THREADS];
  logic [THREADS*PC_W-1:0] next_pc_vec;
  logic [THREADS*3-1:0]    nzp_vec;
  logic                    diverged_c;
  logic                    have_first;
  logic [PC_W-1:0]         first_pc;
  logic                    next_pc_valid_q;
  logic                    diverged_q;
  logic                    unused_alu_bits;

  for (genvar i = 0; i < int'(THREADS); i++) begin : g_lane
    pc_lane #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk              (clk),
      .reset            (reset),
      .enable           (bus.thread_enable[i]),
      .core_state       (bus.core_state),
      .current_pc       (bus.current_pc),
      .pc_mux           (bus.decoded_pc_mux),
      .decoded_nzp      (bus.decoded_nzp),
      .immediate        (bus.decoded_immediate),
      .nzp_write_enable (bus.decoded_nzp_write_enable),
      .always_execute   (bus.decoded_always_execute),
      .predicate        (bus.predicate_mask[i]),
      .cmp_result       (bus.alu_out[i*DATA_W +: 3]),
      .next_pc          (lane_pc[i]),
      .nzp              (lane_nzp[i]),
      .next_pc_c        (lane_pc_c[i])
    );
  end

  // Flatten lane registers onto the bus vectors.
  always_comb begin
    next_pc_vec = '0;
    nzp_vec     = '0;
    for (int i = 0; i < int'(THREADS); i++) begin
      next_pc_vec[i*PC_W +: PC_W] = lane_pc[i];
      nzp_vec[i*3 +: 3]           = lane_nzp[i];
    end
  end

  // Divergent when any enabled lane's new PC differs from the first enabled lane's.
  always_comb begin
    diverged_c = 1'b0;
    have_first = 1'b0;
    first_pc   = '0;
    for (int i = 0; i < int'(THREADS); i++) begin
      if (bus.thread_enable[i]) begin
        if (!have_first) begin
          have_first = 1'b1;
          first_pc   = lane_pc_c[i];
        end else if (lane_pc_c[i] != first_pc) begin
          diverged_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_pc_valid_q <= 1'b0;
      diverged_q      <= 1'b0;
    end else begin
      next_pc_valid_q <= (bus.core_state == ST_EXECUTE);
      if (bus.core_state == ST_EXECUTE) diverged_q <= diverged_c;
    end
  end

  assign bus.next_pc       = next_pc_vec;
  assign bus.nzp           = nzp_vec;
  assign bus.next_pc_valid = next_pc_valid_q;
  assign bus.diverged      = diverged_q;

  // Only the low three bits of each lane's ALU result carry the CMP flags.
  assign unused_alu_bits = ^bus.alu_out;

endmodule
